product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the 16-bit multiplier: consumes its 32-bit unsigned products over a
//   valid/ready handshake and sums BLOCK_LEN consecutive products into one wide result.
//   Emits the finished sum through an output valid/ready handshake, with a sticky overflow flag.
//   Used for dot-product and FIR-style multiply-accumulate datapaths.
// PARAMETERS
//   IN_WIDTH   32  width of each incoming product (unsigned)
//   ACC_WIDTH  40  accumulator/result width; must be >= IN_WIDTH+1 (elaboration error otherwise)
//   BLOCK_LEN  16  products summed per result; must be >= 1
// PORTS
//   Clock_In          in   1              rising-edge clock
//   Reset_In          in   1              asynchronous, active-high reset
//   Clear_In          in   1              synchronous abort: discard partial block and pending result
//   Product_In        in   IN_WIDTH       product from the multiplier
//   Product_Valid_In  in   1              Product_In is valid this cycle
//   Product_Ready_Out out  1              block can accept a product this cycle
//   Sum_Out           out  ACC_WIDTH      completed block sum
//   Sum_Valid_Out     out  1              Sum_Out/Overflow_Out are valid
//   Sum_Ready_In      in   1              consumer accepts the sum this cycle
//   Overflow_Out      out  1              the sum wrapped past 2^ACC_WIDTH during this block
//   Count_Out         out  clog2(BLOCK_LEN+1)  products accepted in the current block
// BEHAVIOUR
//   Reset (async, Reset_In=1): state=ACCUM, accumulator=0, Count_Out=0, Sum_Out=0,
//     Sum_Valid_Out=0, Overflow_Out=0, Product_Ready_Out=1 once reset is released.
//   States:
//     ACCUM: Product_Ready_Out=1, Sum_Valid_Out=0.
//     HOLD:  Product_Ready_Out=0, Sum_Valid_Out=1. Sum_Out and Overflow_Out are stable.
//   Accept: Product_Valid_In & Product_Ready_Out at a rising edge.
//     acc <= acc + zero-extend(Product_In). Count_Out increments.
//     Overflow is set if the ACC_WIDTH-bit add carries out; it is sticky for the rest of the block.
//     The sum wraps modulo 2^ACC_WIDTH (no saturation).
//   Block end: the accept that makes count == BLOCK_LEN loads Sum_Out with the new sum and
//     Overflow_Out with the updated flag. On the next cycle: state=HOLD, Sum_Valid_Out=1.
//     Latency is 1 cycle from the final accept to valid. The accumulator, count and internal
//     overflow clear in the same edge.
//   HOLD exit: Sum_Valid_Out & Sum_Ready_In -> next cycle state=ACCUM, Sum_Valid_Out=0.
//     Sum_Out holds its last value until it is overwritten. Products are never accepted in HOLD.
//     Maximum throughput is 1 result per BLOCK_LEN+1 cycles.
//   BLOCK_LEN=1: every accepted product goes straight to HOLD.
//   Clear_In=1 (sync) has priority over accept and output handshakes in the same cycle:
//     next cycle state=ACCUM, acc=0, count=0, Sum_Valid_Out=0, Overflow_Out=0.
//     Any product presented in that cycle is dropped, even though Product_Ready_Out may be 1.
//     Sum_Out is not cleared.
//   Reset mid-block or mid-HOLD: all state is lost immediately (async) and the pending result
//     is not delivered.
//   Product_Valid_In low: no change. Gaps between products are allowed at any point.
//   Count_Out reads 0..BLOCK_LEN-1 in ACCUM and 0 in HOLD.
// TESTING
//   1. BLOCK_LEN=4; send 3,5,7,9 back-to-back, Sum_Ready_In=1 -> Sum_Out=24 and Sum_Valid_Out=1
//      one cycle after the 4th accept, Overflow_Out=0; the next cycle is ACCUM.
//   2. BLOCK_LEN=4; send 4 x 32'hFFFF_FFFF, ACC_WIDTH=33 ->
//      Sum_Out = (4*(2^32-1)) mod 2^33 = 33'h1_FFFF_FFFC, Overflow_Out=1.
//      The next block of 4 x 1 gives Sum_Out=4, Overflow_Out=0.
//   3. Backpressure: Sum_Ready_In=0 for 5 cycles after a block completes -> Sum_Valid_Out stays 1,
//      Sum_Out stays stable, Product_Ready_Out=0, and presented products are not counted.
//      Raising Sum_Ready_In releases the block.
//   4. Clear mid-block: accept 10,20, then Clear_In=1 while Product_Valid_In=1 with 30 ->
//      Count_Out=0, and the next 4 products 1,1,1,1 give Sum_Out=4.
//   5. Async reset asserted between clock edges in HOLD -> Sum_Valid_Out=0 and Overflow_Out=0
//      immediately; Count_Out=0.
//   6. Random gaps on Product_Valid_In and Sum_Ready_In, with products taken from a 16x16
//      reference multiply -> every Sum_Out matches a golden model of the sum of BLOCK_LEN products.

Source files
------------

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: handshake bundle between the multiplier, the product accumulator and the sum consumer
//   Product_In/Product_Valid_In/Product_Ready_Out : incoming product stream
//   Sum_Out/Sum_Valid_Out/Sum_Ready_In/Overflow_Out : outgoing block result stream
//   Count_Out : products accepted in the current block
//   Clear_In  : synchronous abort of the partial block and any pending result
//   master modport drives products and consumes sums; slave modport is the accumulator
interface product_accumulator_if #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 5
);
  logic                 Clear_In;
  logic [IN_WIDTH-1:0]  Product_In;
  logic                 Product_Valid_In;
  logic                 Product_Ready_Out;
  logic [ACC_WIDTH-1:0] Sum_Out;
  logic                 Sum_Valid_Out;
  logic                 Sum_Ready_In;
  logic                 Overflow_Out;
  logic [CNT_WIDTH-1:0] Count_Out;
  modport master (
    output Clear_In, Product_In, Product_Valid_In, Sum_Ready_In,
    input  Product_Ready_Out, Sum_Out, Sum_Valid_Out, Overflow_Out, Count_Out
  );
  modport slave (
    input  Clear_In, Product_In, Product_Valid_In, Sum_Ready_In,
    output Product_Ready_Out, Sum_Out, Sum_Valid_Out, Overflow_Out, Count_Out
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums BLOCK_LEN unsigned products into one wrapped ACC_WIDTH result with sticky overflow
//   Clock_In : rising-edge clock
//   Reset_In : asynchronous active-high reset
//   bus      : product_accumulator_if slave (product input stream, sum output stream, clear, count)
module product_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int BLOCK_LEN = 16
) (
  input logic              Clock_In,
  input logic              Reset_In,
  product_accumulator_if.slave bus
);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  generate
    if (ACC_WIDTH < IN_WIDTH + 1) begin : g_bad_acc
      $error("product_accumulator: ACC_WIDTH must be >= IN_WIDTH+1");
    end
    if (BLOCK_LEN < 1) begin : g_bad_len
      $error("product_accumulator: BLOCK_LEN must be >= 1");
    end
  endgenerate
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_sum;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 r_ovf_out;
  logic [ACC_WIDTH:0]   w_add;
  logic                 w_ovf;
  logic                 w_last;
  // one extra bit on the adder exposes the carry that feeds the sticky overflow
  always_comb begin
    w_add  = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, bus.Product_In};
    w_ovf  = r_ovf | w_add[ACC_WIDTH];
    w_last = r_count == CW'(BLOCK_LEN - 1);
  end
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_sum     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (bus.Clear_In) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (bus.Product_Valid_In) begin
        if (w_last) begin
          r_state   <= HOLD;
          r_sum     <= w_add[ACC_WIDTH-1:0];
          r_ovf_out <= w_ovf;
          r_acc     <= '0;
          r_count   <= '0;
          r_ovf     <= 1'b0;
        end else begin
          r_acc   <= w_add[ACC_WIDTH-1:0];
          r_count <= r_count + CW'(1);
          r_ovf   <= w_ovf;
        end
      end
    end else if (bus.Sum_Ready_In) begin
      r_state <= ACCUM;
    end
  end
  assign bus.Product_Ready_Out = r_state == ACCUM;
  assign bus.Sum_Valid_Out     = r_state == HOLD;
  assign bus.Sum_Out           = r_sum;
  assign bus.Overflow_Out      = r_ovf_out;
  assign bus.Count_Out         = r_count;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: vector table, corner sequences and randomized run against a queue-based block-sum model
module tb_product_accumulator;
  localparam int IW = 32;
  localparam int AW = 33;
  localparam int BL = 4;
  localparam int CW = $clog2(BL + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  product_accumulator_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  product_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .BLOCK_LEN(BL)) dut (
    .Clock_In(clk),
    .Reset_In(rst),
    .bus(bus)
  );
  typedef struct {
    logic        v;
    logic [31:0] p;
    logic        sr;
    logic        cl;
    logic        ev;
    logic [32:0] esum;
    logic        eovf;
    int          ecnt;
  } vec_t;
  vec_t tv[$];
  longint unsigned q[$];
  logic        m_hold = 1'b0;
  logic [32:0] m_sum = '0;
  logic        m_ovf = 1'b0;
  function automatic void chk(string n, longint unsigned a, longint unsigned e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic void add(logic v, logic [31:0] p, logic sr, logic cl, logic ev, logic [32:0] es, logic eo, int ec);
    tv.push_back('{v, p, sr, cl, ev, es, eo, ec});
  endfunction
  function automatic void model_reset();
    q.delete();
    m_hold = 1'b0;
    m_sum  = '0;
    m_ovf  = 1'b0;
  endfunction
  // block result is the plain sum of the accepted products; overflow means the true sum did not fit in AW bits
  function automatic void model_edge(logic v, logic [31:0] p, logic sr, logic cl);
    longint unsigned tot;
    if (cl) begin
      q.delete();
      m_hold = 1'b0;
      m_ovf  = 1'b0;
    end else if (!m_hold) begin
      if (v) begin
        q.push_back(longint'(p));
        if (q.size() == BL) begin
          tot = 0;
          foreach (q[i]) tot += q[i];
          m_sum  = tot[32:0];
          m_ovf  = tot >= (64'd1 << AW);
          m_hold = 1'b1;
          q.delete();
        end
      end
    end else if (sr) begin
      m_hold = 1'b0;
    end
  endfunction
  function automatic void model_check();
    chk("valid", longint'(bus.Sum_Valid_Out), longint'(m_hold));
    chk("ready", longint'(bus.Product_Ready_Out), longint'(!m_hold));
    chk("count", longint'(bus.Count_Out), longint'(q.size()));
    chk("sum", longint'(bus.Sum_Out), longint'(m_sum));
    if (m_hold) chk("ovf", longint'(bus.Overflow_Out), longint'(m_ovf));
  endfunction
  task automatic cycle(input logic v, input logic [31:0] p, input logic sr, input logic cl);
    bus.Product_Valid_In = v;
    bus.Product_In       = p;
    bus.Sum_Ready_In     = sr;
    bus.Clear_In         = cl;
    @(posedge clk);
    model_edge(v, p, sr, cl);
    @(negedge clk);
    model_check();
  endtask
  initial begin
    logic [15:0] a, b;
    bus.Product_Valid_In = 1'b0;
    bus.Product_In       = '0;
    bus.Sum_Ready_In     = 1'b0;
    bus.Clear_In         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", longint'(bus.Sum_Valid_Out), 0);
    chk("rst_ready", longint'(bus.Product_Ready_Out), 1);
    chk("rst_count", longint'(bus.Count_Out), 0);
    chk("rst_sum", longint'(bus.Sum_Out), 0);
    chk("rst_ovf", longint'(bus.Overflow_Out), 0);
    add(1, 3, 1, 0, 0, 0, 0, 1);
    add(1, 5, 1, 0, 0, 0, 0, 2);
    add(1, 7, 1, 0, 0, 0, 0, 3);
    add(1, 9, 1, 0, 1, 24, 0, 0);
    add(1, 100, 1, 0, 0, 24, 0, 0);
    add(1, 10, 1, 0, 0, 24, 0, 1);
    add(1, 20, 1, 0, 0, 24, 0, 2);
    add(1, 30, 1, 1, 0, 24, 0, 0);
    add(1, 1, 1, 0, 0, 24, 0, 1);
    add(1, 1, 1, 0, 0, 24, 0, 2);
    add(1, 1, 1, 0, 0, 24, 0, 3);
    add(1, 1, 1, 0, 1, 4, 0, 0);
    add(0, 0, 1, 0, 0, 4, 0, 0);
    add(1, 32'hFFFF_FFFF, 1, 0, 0, 4, 0, 1);
    add(0, 0, 1, 0, 0, 4, 0, 1);
    add(1, 32'hFFFF_FFFF, 1, 0, 0, 4, 0, 2);
    add(1, 32'hFFFF_FFFF, 1, 0, 0, 4, 0, 3);
    add(1, 32'hFFFF_FFFF, 1, 0, 1, 33'h1_FFFF_FFFC, 1, 0);
    add(0, 0, 1, 0, 0, 33'h1_FFFF_FFFC, 1, 0);
    add(1, 1, 1, 0, 0, 33'h1_FFFF_FFFC, 0, 1);
    add(1, 1, 1, 0, 0, 33'h1_FFFF_FFFC, 0, 2);
    add(1, 1, 1, 0, 0, 33'h1_FFFF_FFFC, 0, 3);
    add(1, 1, 1, 0, 1, 4, 0, 0);
    add(0, 0, 1, 0, 0, 4, 0, 0);
    foreach (tv[i]) begin
      cycle(tv[i].v, tv[i].p, tv[i].sr, tv[i].cl);
      chk($sformatf("tv%0d_valid", i), longint'(bus.Sum_Valid_Out), longint'(tv[i].ev));
      chk($sformatf("tv%0d_ready", i), longint'(bus.Product_Ready_Out), longint'(!tv[i].ev));
      chk($sformatf("tv%0d_count", i), longint'(bus.Count_Out), longint'(tv[i].ecnt));
      chk($sformatf("tv%0d_sum", i), longint'(bus.Sum_Out), longint'(tv[i].esum));
      if (tv[i].ev) chk($sformatf("tv%0d_ovf", i), longint'(bus.Overflow_Out), longint'(tv[i].eovf));
    end
    for (int i = 0; i < BL; i++) cycle(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 50, 0, 0);
      chk("bp_valid", longint'(bus.Sum_Valid_Out), 1);
      chk("bp_sum", longint'(bus.Sum_Out), 8);
      chk("bp_ready", longint'(bus.Product_Ready_Out), 0);
    end
    cycle(0, 0, 1, 0);
    chk("bp_release", longint'(bus.Sum_Valid_Out), 0);
    for (int i = 0; i < BL; i++) cycle(1, 32'hFFFF_FFFF, 0, 0);
    cycle(1, 7, 0, 1);
    chk("clr_hold_valid", longint'(bus.Sum_Valid_Out), 0);
    chk("clr_hold_sum", longint'(bus.Sum_Out), 64'h1_FFFF_FFFC);
    for (int i = 0; i < BL; i++) cycle(1, 32'hFFFF_FFFF, 0, 0);
    chk("pre_rst_ovf", longint'(bus.Overflow_Out), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", longint'(bus.Sum_Valid_Out), 0);
    chk("arst_ovf", longint'(bus.Overflow_Out), 0);
    chk("arst_count", longint'(bus.Count_Out), 0);
    chk("arst_sum", longint'(bus.Sum_Out), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1, 6, 1, 0);
    chk("post_rst_count", longint'(bus.Count_Out), 1);
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle($urandom_range(0, 2) != 0, {16'd0, a} * {16'd0, b}, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
